// File: rtl/alu_shift_sequencer.sv
// Multi-cycle left-shift sequencer: shift-by-4 passes first, then shift-by-1 passes.
// Optional sticky shifted-out-one flag enabled by defining ALU_SHIFT_STICKY_EN.
module alu_shift_sequencer #(
    parameter int N  = 16,
    parameter int AW = 5
) (
    input  logic          clk,
    input  logic          rstb,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [N-1:0]  in_a,
    input  logic [AW-1:0] in_amt,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [N-1:0]  out_z,
    output logic          out_ovf
);

    // Counter must hold both the raw amount and the clamp value N.
    localparam int CW = ($clog2(N + 1) > AW) ? $clog2(N + 1) : AW;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT4 = 2'd1,
        SHIFT1 = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t          state_r;
    state_t          state_nxt_s;
    logic [N-1:0]    reg_r;
    logic [N-1:0]    reg_nxt_s;
    logic [CW-1:0]   cnt_r;
    logic [CW-1:0]   cnt_nxt_s;
    logic [CW-1:0]   amt_ext_s;
    logic [CW-1:0]   amt_clamp_s;

    // Largest remaining step decides where the sequencer goes next.
    function automatic state_t route(input logic [CW-1:0] c);
        if (c >= CW'(4)) begin
            route = SHIFT4;
        end else if (c != {CW{1'b0}}) begin
            route = SHIFT1;
        end else begin
            route = DONE;
        end
    endfunction

    // Clamp the requested amount to the datapath width.
    always_comb begin
        amt_ext_s = CW'(in_amt);
        if (amt_ext_s >= CW'(N)) begin
            amt_clamp_s = CW'(N);
        end else begin
            amt_clamp_s = amt_ext_s;
        end
    end

`ifdef ALU_SHIFT_STICKY_EN
    logic ovf_r;
    logic ovf_nxt_s;
`endif

    // Next-state and datapath update.
    always_comb begin
        state_nxt_s = state_r;
        reg_nxt_s   = reg_r;
        cnt_nxt_s   = cnt_r;
`ifdef ALU_SHIFT_STICKY_EN
        ovf_nxt_s   = ovf_r;
`endif
        case (state_r)
            IDLE: begin
                if (in_valid) begin
                    reg_nxt_s   = in_a;
                    cnt_nxt_s   = amt_clamp_s;
                    state_nxt_s = route(amt_clamp_s);
`ifdef ALU_SHIFT_STICKY_EN
                    ovf_nxt_s   = 1'b0;
`endif
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            SHIFT4: begin
                reg_nxt_s   = reg_r << 4;
                cnt_nxt_s   = cnt_r - CW'(4);
                state_nxt_s = route(cnt_r - CW'(4));
`ifdef ALU_SHIFT_STICKY_EN
                ovf_nxt_s   = ovf_r | (|reg_r[N-1:N-4]);
`endif
            end
            SHIFT1: begin
                reg_nxt_s   = reg_r << 1;
                cnt_nxt_s   = cnt_r - CW'(1);
                state_nxt_s = route(cnt_r - CW'(1));
`ifdef ALU_SHIFT_STICKY_EN
                ovf_nxt_s   = ovf_r | reg_r[N-1];
`endif
            end
            DONE: begin
                if (out_ready) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = DONE;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_r <= IDLE;
            reg_r   <= {N{1'b0}};
            cnt_r   <= {CW{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            reg_r   <= reg_nxt_s;
            cnt_r   <= cnt_nxt_s;
        end
    end

`ifdef ALU_SHIFT_STICKY_EN
    // Sticky shifted-out flag register.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            ovf_r <= 1'b0;
        end else begin
            ovf_r <= ovf_nxt_s;
        end
    end
    assign out_ovf = ovf_r;
`else
    assign out_ovf = 1'b0;
`endif

    assign out_z     = reg_r;
    assign in_ready  = (state_r == IDLE);
    assign out_valid = (state_r == DONE);

endmodule

// File: tb/tb_alu_shift_sequencer.sv
// Self-checking bench for alu_shift_sequencer (N=16, AW=5), random and directed,
// against an arithmetic reference model; honours ALU_SHIFT_STICKY_EN.
module tb_alu_shift_sequencer;

`ifdef ALU_SHIFT_STICKY_EN
    localparam bit STICKY = 1'b1;
`else
    localparam bit STICKY = 1'b0;
`endif

    logic        clk;
    logic        rstb;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_a;
    logic [4:0]  in_amt;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_z;
    logic        out_ovf;

    int tests_run = 0;
    int tests_failed = 0;

    alu_shift_sequencer #(.N(16), .AW(5)) dut (
        .clk(clk), .rstb(rstb),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_amt(in_amt),
        .out_valid(out_valid), .out_ready(out_ready), .out_z(out_z), .out_ovf(out_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: plain arithmetic on a 32-bit widening of the operand.
    function automatic int clampv(input int amt);
        return (amt > 16) ? 16 : amt;
    endfunction

    function automatic logic [15:0] model_z(input logic [15:0] a, input int amt);
        logic [31:0] w;
        w = {16'h0000, a} << amt;
        return w[15:0];
    endfunction

    function automatic logic model_ovf(input logic [15:0] a, input int amt);
        logic [31:0] w;
        w = {16'h0000, a} << clampv(amt);
        return STICKY & (w[31:16] != 16'h0000);
    endfunction

    function automatic int model_lat(input int amt);
        return 1 + clampv(amt) / 4 + clampv(amt) % 4;
    endfunction

    // Stimulus driver: one accept, wait for result, optionally release it.
    task automatic run_op(input logic [15:0] a, input logic [4:0] amt, input bit release_out,
                          output logic [15:0] z, output logic ovf, output int lat);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        in_valid = 1'b1;
        in_a     = a;
        in_amt   = amt;
        @(posedge clk);
        lat = 1;
        #1;
        in_valid = 1'b0;
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            lat++;
            #1;
        end
        z   = out_z;
        ovf = out_ovf;
        if (release_out) begin
            @(negedge clk);
            out_ready = 1'b1;
            @(posedge clk);
            #1;
            out_ready = 1'b0;
        end
    endtask

    task automatic test_reset();
        rstb = 1'b0;
        in_valid = 1'b0;
        in_a = 16'h0000;
        in_amt = 5'd0;
        out_ready = 1'b0;
        #12;
        tests_run++;
        if (out_z !== 16'h0000 || out_valid !== 1'b0 || out_ovf !== 1'b0 || in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset: z=%h v=%b ovf=%b rdy=%b, want z=0000 v=0 ovf=0 rdy=1",
                     out_z, out_valid, out_ovf, in_ready);
        end
        @(negedge clk);
        rstb = 1'b1;
    endtask

    task automatic test_directed();
        logic [15:0] ta [4] = '{16'h1234, 16'hBEEF, 16'hFFFF, 16'h0001};
        logic [4:0]  tm [4] = '{5'd5, 5'd0, 5'd20, 5'd3};
        logic [15:0] ez [4] = '{16'h4680, 16'hBEEF, 16'h0000, 16'h0008};
        logic        eo [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        int          el [4] = '{3, 1, 5, 4};
        logic [15:0] z;
        logic        ovf;
        int          lat;
        for (int i = 0; i < 4; i++) begin
            run_op(ta[i], tm[i], 1'b1, z, ovf, lat);
            tests_run++;
            if (z !== ez[i] || ovf !== (eo[i] & STICKY) || lat !== el[i]) begin
                tests_failed++;
                $display("FAIL directed[%0d]: z=%h ovf=%b lat=%0d, want z=%h ovf=%b lat=%0d",
                         i, z, ovf, lat, ez[i], eo[i] & STICKY, el[i]);
            end
        end
    endtask

    task automatic test_random();
        logic [15:0] a;
        logic [4:0]  amt;
        logic [15:0] z;
        logic        ovf;
        int          lat;
        for (int i = 0; i < 40; i++) begin
            a   = 16'($urandom);
            amt = 5'($urandom_range(0, 31));
            run_op(a, amt, 1'b1, z, ovf, lat);
            tests_run++;
            if (z !== model_z(a, int'(amt)) || ovf !== model_ovf(a, int'(amt))
                || lat !== model_lat(int'(amt))) begin
                tests_failed++;
                $display("FAIL random[%0d] a=%h amt=%0d: z=%h ovf=%b lat=%0d, want z=%h ovf=%b lat=%0d",
                         i, a, amt, z, ovf, lat, model_z(a, int'(amt)),
                         model_ovf(a, int'(amt)), model_lat(int'(amt)));
            end
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] z;
        logic        ovf;
        int          lat;
        int          bad;
        bad = 0;
        run_op(16'hA5C3, 5'd6, 1'b0, z, ovf, lat);
        tests_run++;
        if (z !== model_z(16'hA5C3, 6) || ovf !== model_ovf(16'hA5C3, 6) || lat !== model_lat(6)) begin
            tests_failed++;
            $display("FAIL bp_result: z=%h ovf=%b lat=%0d, want z=%h ovf=%b lat=%0d",
                     z, ovf, lat, model_z(16'hA5C3, 6), model_ovf(16'hA5C3, 6), model_lat(6));
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            in_valid = ~in_valid;
            in_a     = 16'($urandom);
            in_amt   = 5'($urandom_range(0, 31));
            @(posedge clk);
            #1;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_z !== model_z(16'hA5C3, 6)
                || out_ovf !== model_ovf(16'hA5C3, 6)) bad++;
        end
        tests_run++;
        if (bad != 0) begin
            tests_failed++;
            $display("FAIL bp_hold: %0d unstable cycles, want 0", bad);
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        tests_run++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL bp_release: rdy=%b v=%b, want rdy=1 v=0", in_ready, out_valid);
        end
        run_op(16'h0F0F, 5'd2, 1'b1, z, ovf, lat);
        tests_run++;
        if (z !== 16'h3C3C || ovf !== 1'b0 || lat !== 3) begin
            tests_failed++;
            $display("FAIL bp_next: z=%h ovf=%b lat=%0d, want z=3c3c ovf=0 lat=3", z, ovf, lat);
        end
    endtask

    task automatic test_reset_midop();
        int pulses;
        pulses = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_a     = 16'h00FF;
        in_amt   = 5'd9;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        rstb = 1'b0;
        #1;
        tests_run++;
        if (out_z !== 16'h0000 || out_valid !== 1'b0 || out_ovf !== 1'b0) begin
            tests_failed++;
            $display("FAIL midop_reset: z=%h v=%b ovf=%b, want 0 0 0", out_z, out_valid, out_ovf);
        end
        @(negedge clk);
        rstb = 1'b1;
        #1;
        tests_run++;
        if (in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL midop_ready: rdy=%b, want 1", in_ready);
        end
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            if (out_valid === 1'b1) pulses++;
        end
        tests_run++;
        if (pulses != 0) begin
            tests_failed++;
            $display("FAIL midop_no_valid: %0d valid cycles, want 0", pulses);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_reset_midop();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
